// File: rtl/gate_vector_checker_if.sv
// ---------------------------------------------------------------------------
// gate_vector_checker_if
//
// Purpose : Vector stream between a gate-under-test harness and the
//           gate_vector_checker. One vector is {in_a, in_b, in_out}. A vector
//           transfers on a rising clock edge when in_valid && in_ready.
//
// Signals :
//   in_valid  master -> slave  vector present on in_a/in_b/in_out
//   in_ready  slave  -> master checker accepts a vector this cycle
//   in_a      master -> slave  first operand applied to the gate under test
//   in_b      master -> slave  second operand applied to the gate under test
//   in_out    master -> slave  gate-under-test output for in_a/in_b
//
// Modports: master (vector source), slave (checker).
// ---------------------------------------------------------------------------
interface gate_vector_checker_if #(
  parameter int W = 16
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] in_out;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output in_out,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  in_out,
    output in_ready
  );

endinterface

// File: rtl/gate_vector_checker.sv
// ---------------------------------------------------------------------------
// gate_vector_checker
//
// Purpose : Receive-side checker for the 16-bit gate library. Consumes a
//           stream of {a, b, dut_out} vectors, computes the expected result
//           for the op latched at start, counts passes/fails, records the
//           first failing vector and reports an overall verdict.
//
// Parameters:
//   W   data width of in_a / in_b / in_out                 (default 16)
//   CW  width of vector counters and indices               (default 16)
//
// Ports:
//   clock            in   rising-edge clock
//   reset_n          in   asynchronous active-low reset
//   start            in   1-cycle pulse: latch op/num_vectors, clear stats, run
//   op               in   0 AND,1 OR,2 XOR,3 NAND,4 NOR,5 NOT a,6 PASS a,7 rsvd
//   num_vectors      in   vectors to check in this run
//   vec              slave modport of gate_vector_checker_if (vector stream)
//   busy             out  checker is in RUN
//   done             out  checker is in DONE (held until the next start)
//   pass             out  done with no mismatches
//   vec_count        out  vectors accepted this run
//   fail_count       out  mismatching vectors, saturating at all-ones
//   first_fail_idx   out  index of the first mismatch (valid if fail_count!=0)
//   first_fail_diff  out  expected ^ in_out of the first mismatch
//   last_diff        out  expected ^ in_out of the most recent vector
//
// Configuration macro:
//   GATE_CHECK_STOP_ON_FAIL_EN  when defined, the first mismatching vector
//                               ends the run (RUN -> DONE at its transfer
//                               edge). When undefined, every run checks all
//                               num_vectors vectors.
// ---------------------------------------------------------------------------
module gate_vector_checker #(
  parameter int W  = 16,
  parameter int CW = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [CW-1:0]         num_vectors,
  gate_vector_checker_if.slave  vec,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CW-1:0]         vec_count,
  output logic [CW-1:0]         fail_count,
  output logic [CW-1:0]         first_fail_idx,
  output logic [W-1:0]          first_fail_diff,
  output logic [W-1:0]          last_diff
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_NOTA = 3'd5,
    OP_PASS = 3'd6,
    OP_RSVD = 3'd7
  } op_t;

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state_q;
  state_t        state_d;
  op_t           op_q;
  logic [CW-1:0] num_q;

  logic          xfer;
  logic          launch;
  logic          last_xfer;
  logic          mismatch;
  logic [W-1:0]  exp_val;
  logic [W-1:0]  diff;

  // -------------------------------------------------------------------------
  // Handshake and status decode, all from the registered state.
  // -------------------------------------------------------------------------
  assign vec.in_ready = (state_q == RUN);
  assign busy         = (state_q == RUN);
  assign done         = (state_q == DONE);
  assign pass         = done && (fail_count == '0);

  assign xfer         = vec.in_valid && vec.in_ready;

  // start is honoured only outside RUN; a start during a run is ignored.
  assign launch       = start && (state_q != RUN);

  // num_q is nonzero whenever state is RUN, so num_q - 1 never underflows
  // while it matters.
  assign last_xfer    = xfer && (vec_count == (num_q - CNT_ONE));

  // -------------------------------------------------------------------------
  // Expected result for the latched op.
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    exp_val = '0;
    unique case (op_q)
      OP_AND:  exp_val = vec.in_a & vec.in_b;
      OP_OR:   exp_val = vec.in_a | vec.in_b;
      OP_XOR:  exp_val = vec.in_a ^ vec.in_b;
      OP_NAND: exp_val = ~(vec.in_a & vec.in_b);
      OP_NOR:  exp_val = ~(vec.in_a | vec.in_b);
      OP_NOTA: exp_val = ~vec.in_a;
      OP_PASS: exp_val = vec.in_a;
      OP_RSVD: exp_val = '0;
      default: exp_val = '0;
    endcase
  end

  assign diff     = exp_val ^ vec.in_out;
  assign mismatch = (diff != '0);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = (num_vectors == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_xfer) begin
          state_d = DONE;
        end
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
        if (xfer && mismatch) begin
          state_d = DONE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Run configuration: op and num_vectors are sampled only at a honoured
  // start, so changes on those inputs mid-run have no effect.
  // -------------------------------------------------------------------------
  // NOTE: this block holds only a handful of control registers, not a memory,
  // so all of them are reset; that keeps every output at 0 after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q  <= OP_AND;
      num_q <= '0;
    end else if (launch) begin
      op_q  <= op_t'(op);
      num_q <= num_vectors;
    end
  end

  // -------------------------------------------------------------------------
  // Statistics. Updated at the transfer edge, so they reflect a vector one
  // cycle after it was accepted.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vec_count       <= '0;
      fail_count      <= '0;
      first_fail_idx  <= '0;
      first_fail_diff <= '0;
      last_diff       <= '0;
    end else if (launch) begin
      vec_count       <= '0;
      fail_count      <= '0;
      first_fail_idx  <= '0;
      first_fail_diff <= '0;
      last_diff       <= '0;
    end else if (xfer) begin
      last_diff <= diff;
      vec_count <= vec_count + CNT_ONE;
      if (mismatch) begin
        if (fail_count != CNT_MAX) begin
          fail_count <= fail_count + CNT_ONE;
        end
        // fail_count == 0 identifies the first mismatch of this run; the
        // index is the pre-increment count, i.e. zero-based.
        if (fail_count == '0) begin
          first_fail_idx  <= vec_count;
          first_fail_diff <= diff;
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_vector_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_vector_checker
//
// Directed bench for gate_vector_checker. u0 uses the default widths; u1 uses
// CW=4 for the counter-saturation run. Inputs change 1 time unit after a
// rising edge and outputs are sampled at that same point, away from the edge.
// Expected values are hand-computed constants in each step.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gate_vector_checker;

  localparam int W = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;

  // u0 controls and outputs
  logic        start0 = 1'b0;
  logic [2:0]  op0 = '0;
  logic [15:0] num0 = '0;
  logic        busy0, done0, pass0;
  logic [15:0] vec_count0, fail_count0, first_fail_idx0;
  logic [W-1:0] first_fail_diff0, last_diff0;

  // u1 controls and outputs
  logic        start1 = 1'b0;
  logic [2:0]  op1 = '0;
  logic [3:0]  num1 = '0;
  logic        busy1, done1, pass1;
  logic [3:0]  vec_count1, fail_count1, first_fail_idx1;
  logic [W-1:0] first_fail_diff1, last_diff1;

  int checks = 0;
  int errors = 0;

  gate_vector_checker_if #(.W(W)) vif0 ();
  gate_vector_checker_if #(.W(W)) vif1 ();

  gate_vector_checker #(.W(W), .CW(16)) u0 (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start0),
    .op              (op0),
    .num_vectors     (num0),
    .vec             (vif0),
    .busy            (busy0),
    .done            (done0),
    .pass            (pass0),
    .vec_count       (vec_count0),
    .fail_count      (fail_count0),
    .first_fail_idx  (first_fail_idx0),
    .first_fail_diff (first_fail_diff0),
    .last_diff       (last_diff0)
  );

  gate_vector_checker #(.W(W), .CW(4)) u1 (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start1),
    .op              (op1),
    .num_vectors     (num1),
    .vec             (vif1),
    .busy            (busy1),
    .done            (done1),
    .pass            (pass1),
    .vec_count       (vec_count1),
    .fail_count      (fail_count1),
    .first_fail_idx  (first_fail_idx1),
    .first_fail_diff (first_fail_diff1),
    .last_diff       (last_diff1)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_run0(input logic [2:0] op, input logic [15:0] n);
    start0 = 1'b1; op0 = op; num0 = n;
    step();
    start0 = 1'b0;
  endtask

  // Present one vector on u0 for one cycle (in_valid left high).
  task automatic send0(input logic [15:0] a, input logic [15:0] b, input logic [15:0] o);
    vif0.in_valid = 1'b1; vif0.in_a = a; vif0.in_b = b; vif0.in_out = o;
    step();
  endtask

  task automatic idle0();
    vif0.in_valid = 1'b0;
  endtask

  task automatic send1(input logic [15:0] a, input logic [15:0] b, input logic [15:0] o);
    vif1.in_valid = 1'b1; vif1.in_a = a; vif1.in_b = b; vif1.in_out = o;
    step();
  endtask

  initial begin
    vif0.in_valid = 1'b0; vif0.in_a = '0; vif0.in_b = '0; vif0.in_out = '0;
    vif1.in_valid = 1'b0; vif1.in_a = '0; vif1.in_b = '0; vif1.in_out = '0;

    // ---- 1: reset state, then reset mid-run --------------------------------
    step(); step();
    check("rst_busy",  {31'd0, busy0}, 32'd0);
    check("rst_done",  {31'd0, done0}, 32'd0);
    check("rst_ready", {31'd0, vif0.in_ready}, 32'd0);
    check("rst_vcnt",  {16'd0, vec_count0}, 32'd0);
    reset_n = 1'b1;
    step();

    start_run0(3'd1, 16'd3);
    check("mid_busy", {31'd0, busy0}, 32'd1);
    send0(16'h0000, 16'h0000, 16'h0001);   // wrong OR result
    idle0();
    check("mid_vcnt", {16'd0, vec_count0}, 32'd1);
    check("mid_fcnt", {16'd0, fail_count0}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy0}, 32'd0);
    check("arst_vcnt", {16'd0, vec_count0}, 32'd0);
    check("arst_fcnt", {16'd0, fail_count0}, 32'd0);
    check("arst_ldiff", {16'd0, last_diff0}, 32'd0);
    check("arst_fdiff", {16'd0, first_fail_diff0}, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check("post_rst_idle", {30'd0, done0, busy0}, 32'd0);

    // ---- 2: OR, all passing, back-to-back ---------------------------------
    start_run0(3'd1, 16'd3);
    send0(16'h0000, 16'hFFFF, 16'hFFFF);
    send0(16'hAAAA, 16'h5555, 16'hFFFF);
    send0(16'h1234, 16'h9876, 16'h9A76);
    idle0();
    check("or_done", {31'd0, done0}, 32'd1);
    check("or_pass", {31'd0, pass0}, 32'd1);
    check("or_vcnt", {16'd0, vec_count0}, 32'd3);
    check("or_fcnt", {16'd0, fail_count0}, 32'd0);
    check("or_ready_done", {31'd0, vif0.in_ready}, 32'd0);

    // ---- 3: OR with one mismatch ------------------------------------------
    start_run0(3'd1, 16'd3);
    send0(16'h0000, 16'h0000, 16'h0000);
    send0(16'h3CC3, 16'h0FF0, 16'h3FF0);   // exp 3FF3, diff 0003
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
    idle0();
    check("orf_done", {31'd0, done0}, 32'd1);
    check("orf_vcnt", {16'd0, vec_count0}, 32'd2);
    check("orf_ldiff", {16'd0, last_diff0}, 32'h0003);
`else
    send0(16'hFFFF, 16'hFFFF, 16'hFFFF);
    idle0();
    check("orf_done", {31'd0, done0}, 32'd1);
    check("orf_vcnt", {16'd0, vec_count0}, 32'd3);
    check("orf_ldiff", {16'd0, last_diff0}, 32'h0000);
`endif
    check("orf_pass", {31'd0, pass0}, 32'd0);
    check("orf_fcnt", {16'd0, fail_count0}, 32'd1);
    check("orf_fidx", {16'd0, first_fail_idx0}, 32'd1);
    check("orf_fdiff", {16'd0, first_fail_diff0}, 32'h0003);

    // ---- 4: stalls with in_valid pattern 1,0,0,1,0,1 (AND) ----------------
    start_run0(3'd0, 16'd3);
    send0(16'hF0F0, 16'hFF00, 16'hF000);
    idle0(); step();
    step();
    send0(16'h1234, 16'h00FF, 16'h0034);
    idle0(); step();
    check("stall_busy", {31'd0, busy0}, 32'd1);
    check("stall_vcnt2", {16'd0, vec_count0}, 32'd2);
    send0(16'hFFFF, 16'hA5A5, 16'hA5A5);
    check("stall_done", {31'd0, done0}, 32'd1);
    check("stall_vcnt3", {16'd0, vec_count0}, 32'd3);
    send0(16'h0000, 16'h0000, 16'h1111);   // offered in DONE, not accepted
    idle0();
    check("stall_no_xfer", {16'd0, vec_count0}, 32'd3);
    check("stall_no_fail", {31'd0, pass0}, 32'd1);
    check("stall_ready", {31'd0, vif0.in_ready}, 32'd0);

    // ---- 5a: num_vectors = 0 ----------------------------------------------
    start_run0(3'd1, 16'd0);
    check("zero_done", {31'd0, done0}, 32'd1);
    check("zero_pass", {31'd0, pass0}, 32'd1);
    check("zero_vcnt", {16'd0, vec_count0}, 32'd0);

    // ---- 5b: start during RUN is ignored (XOR run) -------------------------
    start_run0(3'd2, 16'd2);
    send0(16'h00FF, 16'h0F0F, 16'h0FF0);
    idle0();
    start_run0(3'd7, 16'd5);
    check("ign_busy", {31'd0, busy0}, 32'd1);
    check("ign_vcnt", {16'd0, vec_count0}, 32'd1);
    send0(16'hAAAA, 16'hFFFF, 16'h5555);   // correct for XOR, wrong for op 7
    idle0();
    check("ign_done", {31'd0, done0}, 32'd1);
    check("ign_pass", {31'd0, pass0}, 32'd1);
    check("ign_vcnt2", {16'd0, vec_count0}, 32'd2);

    // ---- 5c: NAND / NOR / NOT / PASS passing run --------------------------
    start_run0(3'd3, 16'd2);
    send0(16'hF0F0, 16'hFF00, 16'h0FFF);
    send0(16'h1111, 16'h1111, 16'hEEEE);
    idle0();
    check("nand_pass", {31'd0, pass0}, 32'd1);
    start_run0(3'd4, 16'd1);
    send0(16'h0F0F, 16'h00FF, 16'hF000);
    idle0();
    check("nor_pass", {31'd0, pass0}, 32'd1);
    start_run0(3'd5, 16'd1);
    send0(16'h00FF, 16'h1234, 16'hFF00);
    idle0();
    check("nota_pass", {31'd0, pass0}, 32'd1);
    start_run0(3'd6, 16'd1);
    send0(16'hBEEF, 16'h0000, 16'hBEEF);
    idle0();
    check("passa_pass", {31'd0, pass0}, 32'd1);

    // ---- 5d: op 7 with in_out = 0001 fails --------------------------------
    start_run0(3'd7, 16'd1);
    send0(16'hFFFF, 16'hFFFF, 16'h0001);
    idle0();
    check("rsvd_done", {31'd0, done0}, 32'd1);
    check("rsvd_pass", {31'd0, pass0}, 32'd0);
    check("rsvd_fcnt", {16'd0, fail_count0}, 32'd1);
    check("rsvd_fdiff", {16'd0, first_fail_diff0}, 32'h0001);
    check("rsvd_ldiff", {16'd0, last_diff0}, 32'h0001);

    // ---- 6: CW=4, 15 wrong vectors, then restart --------------------------
    start1 = 1'b1; op1 = 3'd1; num1 = 4'd15;
    step();
    start1 = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      send1(16'h0000, 16'h0000, 16'(i));
    end
    vif1.in_valid = 1'b0;
    check("sat_done", {31'd0, done1}, 32'd1);
    check("sat_pass", {31'd0, pass1}, 32'd0);
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
    check("sat_fcnt", {28'd0, fail_count1}, 32'h1);
    check("sat_vcnt", {28'd0, vec_count1}, 32'h1);
`else
    check("sat_fcnt", {28'd0, fail_count1}, 32'hF);
    check("sat_vcnt", {28'd0, vec_count1}, 32'hF);
    check("sat_ldiff", {16'd0, last_diff1}, 32'h000F);
`endif
    check("sat_fidx", {28'd0, first_fail_idx1}, 32'd0);
    check("sat_fdiff", {16'd0, first_fail_diff1}, 32'h0001);
    start1 = 1'b1; op1 = 3'd1; num1 = 4'd2;
    step();
    start1 = 1'b0;
    check("clr_busy", {31'd0, busy1}, 32'd1);
    check("clr_fcnt", {28'd0, fail_count1}, 32'd0);
    check("clr_vcnt", {28'd0, vec_count1}, 32'd0);
    check("clr_fidx", {28'd0, first_fail_idx1}, 32'd0);
    check("clr_fdiff", {16'd0, first_fail_diff1}, 32'd0);
    check("clr_ldiff", {16'd0, last_diff1}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
